// File: rtl/execute_stage.sv
// ALU execute stage: single-cycle ALU ops plus a multi-cycle shift-add multiplier
// that stalls upstream. Result and condition flags are registered for the memory stage.
module execute_stage #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] ALUoutput,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Zero and negative flags of a result about to be registered.
    function automatic logic [1:0] zn_flags(input logic [WIDTH-1:0] r);
        return {(r == {WIDTH{1'b0}}), r[WIDTH-1]};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;

    logic [SHW-1:0]   shamt_s;
    logic [WIDTH:0]   add_full_s;
    logic [WIDTH:0]   sub_full_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic [WIDTH-1:0] acc_step_s;
    logic [1:0]       alu_zn_s;
    logic [1:0]       acc_zn_s;
    logic             accept_s;

    // Single-cycle ALU result with carry/overflow; MUL and reserved opcodes yield zero here.
    always_comb begin
        shamt_s    = srcB[SHW-1:0];
        add_full_s = {1'b0, srcA} + {1'b0, srcB};
        sub_full_s = {1'b0, srcA} - {1'b0, srcB};
        alu_res_s  = {WIDTH{1'b0}};
        alu_c_s    = 1'b0;
        alu_v_s    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_s = add_full_s[WIDTH-1:0];
                alu_c_s   = add_full_s[WIDTH];
                alu_v_s   = (srcA[WIDTH-1] == srcB[WIDTH-1]) &&
                            (add_full_s[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the unsigned borrow.
                alu_res_s = sub_full_s[WIDTH-1:0];
                alu_c_s   = sub_full_s[WIDTH];
                alu_v_s   = (srcA[WIDTH-1] != srcB[WIDTH-1]) &&
                            (sub_full_s[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_AND:   alu_res_s = srcA & srcB;
            OP_OR:    alu_res_s = srcA | srcB;
            OP_XOR:   alu_res_s = srcA ^ srcB;
            OP_NOT:   alu_res_s = ~srcA;
            OP_SLL:   alu_res_s = srcA << shamt_s;
            OP_SRL:   alu_res_s = srcA >> shamt_s;
            OP_SRA:   alu_res_s = $unsigned($signed(srcA) >>> shamt_s);
            OP_SLT:   alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            OP_PASSB: alu_res_s = srcB;
            default:  alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add iteration of the multiplier and flag helpers.
    always_comb begin
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
        alu_zn_s = zn_flags(alu_res_s);
        acc_zn_s = zn_flags(acc_step_s);
        accept_s = in_valid && !flush;
    end

    // Next-state logic: accept in IDLE, iterate in MUL; flush overrides accept and completion.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        zero_d      = zero_q;
        negative_d  = negative_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (op == OP_MUL)) begin
                    mcand_d  = srcA;
                    mplier_d = srcB;
                    acc_d    = {WIDTH{1'b0}};
                    count_d  = MUL_ITERS;
                    state_d  = S_MUL;
                end else if (accept_s) begin
                    result_d    = alu_res_s;
                    out_valid_d = 1'b1;
                    zero_d      = alu_zn_s[1];
                    negative_d  = alu_zn_s[0];
                    carry_d     = alu_c_s;
                    overflow_d  = alu_v_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (flush) begin
                    count_d = CNT_ZERO;
                    state_d = S_IDLE;
                end else begin
                    acc_d    = acc_step_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        result_d    = acc_step_s;
                        out_valid_d = 1'b1;
                        zero_d      = acc_zn_s[1];
                        negative_d  = acc_zn_s[0];
                        carry_d     = 1'b0;
                        overflow_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mcand_q     <= {WIDTH{1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            count_q     <= CNT_ZERO;
            result_q    <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
        end
    end

    assign stall     = (state_q == S_MUL);
    assign ALUoutput = result_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed steps plus random ops compared with an
// arithmetic reference model of the ALU and multiplier.
module tb_execute_stage;

    logic        CLK;
    logic        reset;
    logic        in_valid;
    logic [3:0]  op;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic        flush;
    logic        stall;
    logic [15:0] ALUoutput;
    logic        out_valid;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    exp_t last;

    execute_stage #(.WIDTH(16), .SHW(4)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .srcA      (srcA),
        .srcB      (srcB),
        .flush     (flush),
        .stall     (stall),
        .ALUoutput (ALUoutput),
        .out_valid (out_valid),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model using plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t   m;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = longint'($signed(a));
        longint sb   = longint'($signed(b));
        longint full = 0;
        longint sres = 0;
        int     sh   = int'(b[3:0]);
        m = '0;
        case (o)
            4'd0: begin
                full = ua + ub;
                sres = sa + sb;
                m.c  = (full > 65535);
                m.v  = (sres > 32767) || (sres < -32768);
            end
            4'd1: begin
                full = ua - ub;
                sres = sa - sb;
                m.c  = (ua < ub);
                m.v  = (sres > 32767) || (sres < -32768);
            end
            4'd2:    full = ua & ub;
            4'd3:    full = ua | ub;
            4'd4:    full = ua ^ ub;
            4'd5:    full = ~ua;
            4'd6:    full = ua << sh;
            4'd7:    full = ua >> sh;
            4'd8:    full = sa >>> sh;
            4'd9:    full = (sa < sb) ? 64'sd1 : 64'sd0;
            4'd10:   full = ub;
            4'd11:   full = ua * ub;
            default: full = 0;
        endcase
        m.r = full[15:0];
        m.z = (m.r == 16'h0000);
        m.n = m.r[15];
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input exp_t e);
        check({tag, "_result"}, {16'h0000, ALUoutput}, {16'h0000, e.r});
        check({tag, "_flags"}, {28'h0, zero, negative, carry, overflow}, {28'h0, e.z, e.n, e.c, e.v});
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic v, input logic f);
        @(negedge CLK);
        op = o; srcA = a; srcB = b; in_valid = v; flush = f;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic single(input string tag, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e = model(o, a, b);
        drive(o, a, b, 1'b1, 1'b0);
        tick();
        check_res(tag, e);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
        check({tag, "_stall"}, {31'h0, stall}, 32'd0);
        last = e;
    endtask

    task automatic idle_chk(input string tag);
        drive(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        check({tag, "_valid_low"}, {31'h0, out_valid}, 32'd0);
        check_res({tag, "_held"}, last);
    endtask

    // Multiply; when hold is set an ADD 1+2 waits on in_valid for the whole stall.
    task automatic mul(input string tag, input logic [15:0] a, input logic [15:0] b, input logic hold);
        exp_t e;
        exp_t h;
        int   stalls;
        e = model(4'd11, a, b);
        h = model(4'd0, 16'd1, 16'd2);
        drive(4'd11, a, b, 1'b1, 1'b0);
        tick();
        check({tag, "_start_stall"}, {31'h0, stall}, 32'd1);
        check({tag, "_start_valid"}, {31'h0, out_valid}, 32'd0);
        check_res({tag, "_start_hold"}, last);
        stalls = 1;
        drive(4'd0, 16'd1, 16'd2, hold, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (stall) stalls++;
            if (i == 8) check({tag, "_mid_valid"}, {31'h0, out_valid}, 32'd0);
        end
        check({tag, "_stall_cycles"}, stalls, 32'd16);
        check({tag, "_done_valid"}, {31'h0, out_valid}, 32'd1);
        check_res({tag, "_done"}, e);
        last = e;
        if (hold) begin
            tick();
            check_res({tag, "_held_add"}, h);
            check({tag, "_held_add_valid"}, {31'h0, out_valid}, 32'd1);
            last = h;
        end
    endtask

    // Start a multiply and flush it at busy edge n (1..16).
    task automatic mul_flush(input string tag, input int n);
        drive(4'd11, 16'h1234, 16'h5678, 1'b1, 1'b0);
        tick();
        drive(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i < n; i++) tick();
        drive(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick();
        check({tag, "_stall"}, {31'h0, stall}, 32'd0);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd0);
        check_res({tag, "_unchanged"}, last);
        drive(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        check({tag, "_stall_after"}, {31'h0, stall}, 32'd0);
        check_res({tag, "_still"}, last);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        exp_t        zero_e;
        zero_e   = '0;
        last     = '0;
        reset    = 1'b0;
        in_valid = 1'b0;
        op       = 4'd0;
        srcA     = 16'h0000;
        srcB     = 16'h0000;
        flush    = 1'b0;
        tick();
        tick();
        check_res("reset", zero_e);
        check("reset_valid", {31'h0, out_valid}, 32'd0);
        check("reset_stall", {31'h0, stall}, 32'd0);
        @(negedge CLK);
        reset = 1'b1;
        tick();
        check("post_reset_valid", {31'h0, out_valid}, 32'd0);

        single("add_ovf", 4'd0, 16'h7FFF, 16'h0001);
        check("add_ovf_const", {16'h0, ALUoutput}, 32'h8000);
        idle_chk("add_ovf_after");

        single("sub_eq", 4'd1, 16'd5, 16'd5);
        check("sub_eq_zero", {31'h0, zero}, 32'd1);
        single("sub_borrow", 4'd1, 16'd3, 16'd5);
        check("sub_borrow_const", {16'h0, ALUoutput}, 32'hFFFE);
        check("sub_borrow_carry", {31'h0, carry}, 32'd1);
        idle_chk("sub_after");

        mul("mul_hold", 16'h0123, 16'h0045, 1'b1);
        check("mul_hold_const", {16'h0, last.r}, 32'h0003);
        idle_chk("mul_hold_after");

        mul("mul_ffff", 16'hFFFF, 16'hFFFF, 1'b0);
        check("mul_ffff_const", {16'h0, ALUoutput}, 32'h0001);
        single("sra", 4'd8, 16'h8000, 16'h0004);
        check("sra_const", {16'h0, ALUoutput}, 32'hF800);
        single("slt", 4'd9, 16'hFFFF, 16'h0001);
        check("slt_const", {16'h0, ALUoutput}, 32'h0001);
        single("sll0", 4'd6, 16'hA5C3, 16'hFFF0);
        single("rsvd", 4'd13, 16'h1234, 16'h5678);
        check("rsvd_zero", {31'h0, zero}, 32'd1);
        single("passb", 4'd10, 16'h1111, 16'hBEEF);

        mul_flush("flush5", 5);
        mul_flush("flush16", 16);
        drive(4'd0, 16'd5, 16'd6, 1'b1, 1'b1);
        tick();
        check("idle_flush_valid", {31'h0, out_valid}, 32'd0);
        check_res("idle_flush_held", last);

        drive(4'd11, 16'h00FF, 16'h0003, 1'b1, 1'b0);
        tick();
        drive(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_res("async_reset", zero_e);
        check("async_reset_valid", {31'h0, out_valid}, 32'd0);
        check("async_reset_stall", {31'h0, stall}, 32'd0);
        last = zero_e;
        @(negedge CLK);
        reset = 1'b1;
        single("add_after_reset", 4'd0, 16'd1, 16'd1);
        check("add_after_reset_const", {16'h0, ALUoutput}, 32'h0002);

        for (int k = 0; k < 60; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k % 7 == 0) ra = 16'h8000;
            if (k % 11 == 0) rb = 16'h7FFF;
            if (ro == 4'd11) begin
                mul("rnd_mul", ra, rb, 1'b0);
            end else begin
                single("rnd", ro, ra, rb);
            end
            if (k % 5 == 0) idle_chk("rnd_idle");
        end

        drive(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Stage 2 of the memory-to-memory pipeline: the ALU execute stage. It sits directly upstream of the memory stage.
- Takes decoded operands and an opcode from decode and produces the 16-bit ALUoutput that the memory stage registers and routes to memory write data and address.
- Single-cycle ops complete in one clock. MUL is a multi-cycle shift-add unit that stalls the upstream pipeline.
- Also holds condition flags for branch resolution.

Parameters:
- WIDTH, 16, datapath width. MUL iteration count equals WIDTH.
- SHW, 4, shift-amount bits taken from srcB[SHW-1:0].

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode presents a valid op this cycle.
- op  input  4  opcode (encoding below).
- srcA  input  WIDTH  operand A.
- srcB  input  WIDTH  operand B / shift amount.
- flush  input  1  synchronous kill from branch/hazard logic.
- stall  output  1  high while MUL busy; upstream must hold inputs.
- ALUoutput  output  WIDTH  registered result to memory stage.
- out_valid  output  1  ALUoutput was updated by the last edge.
- zero, negative, carry, overflow  output  1 each  registered flags of last result.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SLL A by B[3:0], 7 SRL, 8 SRA.
  - 9 SLT: signed A<B gives 1, else 0.
  - 10 PASSB.
  - 11 MUL: low WIDTH bits of unsigned product.
  - 12-15 give result 0 with flags updated accordingly.
- Reset (async, reset=0): state IDLE; ALUoutput=0; out_valid=0; stall=0; all flags=0; MUL counter/accumulator=0. Reset mid-MUL aborts immediately.
- FSM states: IDLE, MUL.
- Accept rule: an op is accepted at an edge when in_valid=1, stall=0 and flush=0.
- IDLE, accepted non-MUL op:
  - ALUoutput and flags are loaded at that edge; out_valid=1 for the following cycle. Latency is 1 edge.
  - Back-to-back accepts are allowed every cycle.
- IDLE, accepted MUL (edge 0):
  - Latch multiplicand=A, multiplier=B, acc=0, count=WIDTH; go to MUL.
  - out_valid=0 after edge 0. ALUoutput and flags hold their previous values.
- MUL state:
  - stall=1, driven combinationally from state==MUL.
  - Each edge: if multiplier[0], acc+=multiplicand (mod 2^WIDTH); multiplicand<<=1; multiplier>>=1; count-=1.
  - At edge WIDTH (count 1 to 0): ALUoutput=final acc, flags updated, out_valid=1, state IDLE.
  - stall is high for exactly WIDTH cycles. in_valid during MUL is ignored, with no accept.
- out_valid deasserts the cycle after a result unless another result lands. ALUoutput holds its value indefinitely; the memory stage samples it every cycle.
- Flags, computed on the result being loaded:
  - zero = (result==0); negative = result[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = borrow (A<B unsigned); overflow = signed overflow.
  - All other ops: carry=0, overflow=0.
- Shifts: amount 0 passes A unchanged. SRA replicates bit WIDTH-1.
- flush=1 at an edge:
  - No accept. out_valid=0 after the edge.
  - In MUL: abort to IDLE, stall drops next cycle; ALUoutput and flags are not modified.
  - flush has priority over accept and over MUL completion at the same edge.
- in_valid with flush simultaneously: op discarded.

Test Plan:
- ADD 0x7FFF+0x0001 accepted at edge n -> after edge n: ALUoutput=0x8000, negative=1, overflow=1, carry=0, zero=0, out_valid=1; out_valid=0 next cycle with ALUoutput held.
- SUB 5-5 then SUB 3-5 back-to-back -> 0x0000 with zero=1, carry=0; then 0xFFFE with carry=1, negative=1, zero=0; out_valid high both cycles.
- MUL 0x0123*0x0045 -> stall=1 for 16 cycles; in_valid with ADD held during that time is not consumed; ALUoutput=0x4E6F and out_valid=1 after edge 16; held ADD accepted at edge 17.
- MUL 0xFFFF*0xFFFF -> ALUoutput=0x0001 after 16 cycles. SRA 0x8000 by 4 -> 0xF800. SLT 0xFFFF,0x0001 -> 0x0001.
- MUL started, flush asserted at 5th busy edge -> stall=0 next cycle, out_valid=0, ALUoutput unchanged from prior result.
- Assert reset low asynchronously mid-MUL, between edges -> ALUoutput=0, stall=0, out_valid=0, flags=0 immediately. After release, ADD 1+1 -> 0x0002.
